// File: rtl/cla_pkg.sv
// Shared types and helpers for the serial carry-lookahead sequencer.
// The nibble slice width is fixed; only the operand width varies.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_BITS = 4;

    // Width of the nibble index; a single-nibble operand still keeps one bit.
    function automatic int idx_width(input int nib);
        if (nib > 1) begin
            return $clog2(nib);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/cla_nibble.sv
// Purely combinational 4-bit carry-lookahead slice.
// carry[i] is the carry out of bit i, so carry[3] feeds the next nibble.
module cla_nibble
    import cla_pkg::*;
(
    input  logic [NIB_BITS-1:0] A,
    input  logic [NIB_BITS-1:0] B,
    input  logic                cIn,
    output logic [NIB_BITS-1:0] sum,
    output logic [NIB_BITS-1:0] carry
);

    logic [NIB_BITS-1:0] gen_s;
    logic [NIB_BITS-1:0] prop_s;
    logic [NIB_BITS-1:0] cin_bit_s;

    assign gen_s  = A & B;
    assign prop_s = A ^ B;

    // Flattened lookahead equations: every carry depends only on g/p and cIn.
    always_comb begin
        carry[0] = gen_s[0] | (prop_s[0] & cIn);
        carry[1] = gen_s[1] | (prop_s[1] & gen_s[0])
                 | (prop_s[1] & prop_s[0] & cIn);
        carry[2] = gen_s[2] | (prop_s[2] & gen_s[1])
                 | (prop_s[2] & prop_s[1] & gen_s[0])
                 | (prop_s[2] & prop_s[1] & prop_s[0] & cIn);
        carry[3] = gen_s[3] | (prop_s[3] & gen_s[2])
                 | (prop_s[3] & prop_s[2] & gen_s[1])
                 | (prop_s[3] & prop_s[2] & prop_s[1] & gen_s[0])
                 | (prop_s[3] & prop_s[2] & prop_s[1] & prop_s[0] & cIn);
    end

    assign cin_bit_s = {carry[2:0], cIn};
    assign sum       = prop_s ^ cin_bit_s;

endmodule

// File: rtl/cla_serial_sequencer.sv
// Wide adder that time-shares one 4-bit lookahead slice, LSB nibble first,
// with valid/ready handshakes on the operand and result sides.
module cla_serial_sequencer
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cIn,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] sum,
    output logic             cOut,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB  = WIDTH / NIB_BITS;
    localparam int IDXW = idx_width(NIB);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    if ((WIDTH < NIB_BITS) || ((WIDTH % NIB_BITS) != 0)) begin : g_bad_width
        $error("cla_serial_sequencer: WIDTH must be a positive multiple of 4");
    end

    state_t              state_r;
    state_t              state_next_s;
    logic [WIDTH-1:0]    a_r;
    logic [WIDTH-1:0]    b_r;
    logic [WIDTH-1:0]    sum_r;
    logic                carry_r;
    logic                cout_r;
    logic                ovf_r;
    logic [IDXW-1:0]     idx_r;
    logic                last_s;
    logic [NIB_BITS-1:0] nib_a_s;
    logic [NIB_BITS-1:0] nib_b_s;
    logic [NIB_BITS-1:0] nib_sum_s;
    logic [NIB_BITS-1:0] nib_carry_s;
    logic                in_ready_s;
    logic                out_valid_s;
    logic                busy_s;

    assign last_s  = (idx_r == LAST_IDX);
    assign nib_a_s = a_r[NIB_BITS*int'(idx_r) +: NIB_BITS];
    assign nib_b_s = b_r[NIB_BITS*int'(idx_r) +: NIB_BITS];

    cla_nibble u_nibble (
        .A     (nib_a_s),
        .B     (nib_b_s),
        .cIn   (carry_r),
        .sum   (nib_sum_s),
        .carry (nib_carry_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (inValid) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (outReady) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Handshake and status decode; all are functions of the state register only.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
        case (state_r)
            IDLE: in_ready_s = 1'b1;
            RUN:  busy_s     = 1'b1;
            DONE: begin
                out_valid_s = 1'b1;
                busy_s      = 1'b1;
            end
            default: in_ready_s = 1'b0;
        endcase
    end

    // Operand latch, nibble-serial accumulation and final flag capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            idx_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (inValid) begin
                        a_r     <= A;
                        b_r     <= B;
                        carry_r <= cIn;
                        idx_r   <= '0;
                    end
                end
                RUN: begin
                    sum_r[NIB_BITS*int'(idx_r) +: NIB_BITS] <= nib_sum_s;
                    carry_r <= nib_carry_s[NIB_BITS-1];
                    idx_r   <= idx_r + IDX_ONE;
                    // Overflow compares carries into and out of the MSB.
                    if (last_s) begin
                        cout_r <= nib_carry_s[NIB_BITS-1];
                        ovf_r  <= nib_carry_s[NIB_BITS-1] ^ nib_carry_s[NIB_BITS-2];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign inReady  = in_ready_s;
    assign outValid = out_valid_s;
    assign busy     = busy_s;
    assign sum      = sum_r;
    assign cOut     = cout_r;
    assign ovf      = ovf_r;

endmodule

// File: doc/cla_serial_sequencer.md
Name: cla_serial_sequencer

Overview:
Multi-cycle wide adder controller. It time-shares one 4-bit carry-lookahead slice across a WIDTH-bit operand pair, one nibble per cycle from LSB to MSB. The nibble carry is registered between cycles. The block sits between an upstream operand producer and a downstream result consumer, using valid/ready handshakes on both sides. It is the area-optimised alternative to a full-width lookahead adder.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4, otherwise elaboration fails.
NIB, WIDTH/4, derived; number of nibble cycles per operation; not overridable.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
inValid  input  1  operands A, B and cIn are valid.
inReady  output  1  block can accept operands.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
cIn  input  1  carry into bit 0.
outValid  output  1  result is valid.
outReady  input  1  consumer accepts the result.
sum  output  WIDTH  A+B+cIn, modulo 2^WIDTH.
cOut  output  1  carry out of bit WIDTH-1.
ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: state=IDLE; internal A/B/sum registers, idx, and carry register are cleared.
  - Outputs after reset: sum=0, cOut=0, ovf=0, outValid=0, busy=0, inReady=1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - inReady=1.
  - On inValid && inReady: latch A, B; carry register <= cIn; idx <= 0; go to RUN.
  - No state change without inValid.
- RUN, one nibble per cycle:
  - The slice sees A[4*idx+:4], B[4*idx+:4] and the carry register.
  - At the clock edge: sum[4*idx+:4] <= slice sum; carry register <= slice carry[3]; idx <= idx+1.
  - When idx==NIB-1: also capture cOut and ovf (ovf = slice carry[3] XOR slice carry[2]), then go to DONE.
  - inReady=0 throughout; inValid is ignored.
- DONE:
  - outValid=1.
  - sum, cOut and ovf are held stable until outValid && outReady.
  - On that handshake: go to IDLE and deassert outValid. sum/cOut/ovf keep their last values (no clear).
  - inReady=0 while in DONE. There is no overlap of operations: a new accept happens no earlier than the cycle after the output handshake.
- Latency: if the accept edge is edge k, outValid is high after edge k+NIB (NIB cycles). With outReady held high, throughput is one result per NIB+2 cycles.
- Register rules:
  - Operands are latched, so A/B/cIn may change freely after accept.
  - During RUN, sum bits above the current nibble hold their previous-operation value. Only the DONE value is architecturally defined.
  - idx is clog2(NIB) bits wide, minimum 1 bit.
  - When NIB=1, RUN lasts exactly one cycle.
- Reset mid-operation (RUN or DONE): immediate return to reset values; any in-flight result is discarded with no outValid pulse.
- An outReady held high in IDLE or RUN has no effect.

Decomposition:
- Shared package cla_pkg holds:
  - the state enum type (IDLE, RUN, DONE), 2 bits;
  - the constant NIB_BITS=4;
  - a function returning the idx width for a given NIB.
- One sub-module: cla_nibble, a purely combinational 4-bit lookahead slice.
  - Ports: A[3:0], B[3:0], cIn → sum[3:0], carry[3:0].
  - Computes generate/propagate and lookahead carries per nibble; sum[i] = A^B^carry-in of bit i.
  - The sequencer instantiates exactly one cla_nibble.

Test Plan:
1. WIDTH=16, A=0x1234, B=0x4321, cIn=0, outReady=1 → outValid exactly 4 cycles after accept; sum=0x5555, cOut=0, ovf=0; inReady back to 1 one cycle after the handshake.
2. A=0xFFFF, B=0x0001, cIn=0 → sum=0x0000, cOut=1, ovf=0 (carry ripples through all 4 nibble cycles). Also A=0xFFFF, B=0xFFFF, cIn=1 → sum=0xFFFF, cOut=1, ovf=0.
3. A=0x7FFF, B=0x0001 → sum=0x8000, cOut=0, ovf=1. Also A=0x8000, B=0x8000 → sum=0x0000, cOut=1, ovf=1.
4. Backpressure: outReady=0 for 5 cycles in DONE, with inValid=1 and new operands toggling → sum/cOut/ovf stable, inReady=0, no second accept; after outReady=1, the next accept occurs in IDLE with the new operands.
5. Assert rst asynchronously 2 cycles into RUN (A=0x00FF, B=0x0001) → outputs reset immediately with no outValid pulse; after release, inReady=1 and a fresh operation A=0x0003, B=0x0004 gives 0x0007.
6. WIDTH=4 instance: A=0x9, B=0x8, cIn=1 → outValid 1 cycle after accept; sum=0x2, cOut=1, ovf=1.
